// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle MIPS main control: ULA opcodes,
// instruction opcode/funct encodings, mux select codes, FSM state enum and
// the bundle of control signals driven by the FSM.
package controle_pkg;

    // ULA operation codes
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;
    localparam logic [2:0] ULA_NOR = 3'b100;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ULA operand B select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_QUATRO = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } estado_t;

    typedef struct packed {
        logic [2:0] ula_control;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } sinais_ctrl_t;

endpackage

// File: rtl/decodificador_funct.sv
// R-type funct decoder: maps instr[5:0] to the ULA operation. Unknown funct
// codes fall back to ADD and are flagged through funct_valido.
module decodificador_funct
    import controle_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ula_control,
    output logic       funct_valido
);

    // Translate funct into ULA opcode plus a legality flag
    always_comb begin
        ula_control  = ULA_ADD;
        funct_valido = 1'b1;
        case (funct)
            FN_AND:  ula_control = ULA_AND;
            FN_OR:   ula_control = ULA_OR;
            FN_ADD:  ula_control = ULA_ADD;
            FN_SUB:  ula_control = ULA_SUB;
            FN_SLT:  ula_control = ULA_SLT;
            FN_NOR:  ula_control = ULA_NOR;
            default: begin
                ula_control  = ULA_ADD;
                funct_valido = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// writeback, drives datapath mux selects and write enables, stalls on
// mem_ready for fetches and memory accesses, and keeps a sticky illegal
// instruction flag.
// Optional feature: define PERF_CNT_EN to build the cycle and retired
// instruction counters; otherwise both counter outputs are tied to zero.
module unidade_controle_multiciclo
    import controle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic [2:0]       ULA_control,
    output logic             ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             erro,
    output logic [CNT_W-1:0] cnt_ciclos,
    output logic [CNT_W-1:0] cnt_instr
);

    estado_t      estado_r;
    estado_t      prox_estado_s;
    sinais_ctrl_t ctrl_s;
    logic         seta_erro_s;
    logic         erro_r;
    logic         cond_branch_s;
    logic [2:0]   ula_funct_s;
    logic         funct_valido_s;

    decodificador_funct u_decodificador_funct (
        .funct        (funct),
        .ula_control  (ula_funct_s),
        .funct_valido (funct_valido_s)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r <= S_FETCH;
        end else begin
            estado_r <= prox_estado_s;
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            erro_r <= 1'b0;
        end else if (seta_erro_s) begin
            erro_r <= 1'b1;
        end else begin
            erro_r <= erro_r;
        end
    end

    // Next-state and Moore control outputs; everything idle while in reset
    always_comb begin
        ctrl_s             = '0;
        ctrl_s.ula_control = ULA_ADD;
        prox_estado_s      = estado_r;
        seta_erro_s        = 1'b0;
        if (reset) begin
            prox_estado_s = S_FETCH;
        end else begin
            case (estado_r)
                S_FETCH: begin
                    ctrl_s.ula_src_b = SRCB_QUATRO;
                    ctrl_s.ir_write  = mem_ready;
                    ctrl_s.pc_write  = mem_ready;
                    if (mem_ready) begin
                        prox_estado_s = S_DECODE;
                    end else begin
                        prox_estado_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch target into ULAOut
                    ctrl_s.ula_src_b = SRCB_IMM_SH;
                    case (opcode)
                        OP_RTYPE:      prox_estado_s = S_EXEC;
                        OP_LW, OP_SW:  prox_estado_s = S_MEMADR;
                        OP_BEQ, OP_BNE: prox_estado_s = S_BRANCH;
                        OP_ADDI:       prox_estado_s = S_ADDIEX;
                        OP_J:          prox_estado_s = S_JUMP;
                        default: begin
                            prox_estado_s = S_FETCH;
                            seta_erro_s   = 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    ctrl_s.ula_src_a   = 1'b1;
                    ctrl_s.ula_src_b   = SRCB_REGB;
                    ctrl_s.ula_control = ula_funct_s;
                    if (funct_valido_s) begin
                        prox_estado_s = S_ALUWB;
                    end else begin
                        prox_estado_s = S_FETCH;
                        seta_erro_s   = 1'b1;
                    end
                end
                S_ALUWB: begin
                    ctrl_s.reg_dst   = 1'b1;
                    ctrl_s.reg_write = 1'b1;
                    prox_estado_s    = S_FETCH;
                end
                S_MEMADR: begin
                    ctrl_s.ula_src_a = 1'b1;
                    ctrl_s.ula_src_b = SRCB_IMM;
                    if (opcode == OP_SW) begin
                        prox_estado_s = S_MEMWR;
                    end else begin
                        prox_estado_s = S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    ctrl_s.iord = 1'b1;
                    if (mem_ready) begin
                        prox_estado_s = S_MEMWB;
                    end else begin
                        prox_estado_s = S_MEMRD;
                    end
                end
                S_MEMWB: begin
                    ctrl_s.mem_to_reg = 1'b1;
                    ctrl_s.reg_write  = 1'b1;
                    prox_estado_s     = S_FETCH;
                end
                S_MEMWR: begin
                    // Strobe held until memory accepts the write
                    ctrl_s.iord      = 1'b1;
                    ctrl_s.mem_write = 1'b1;
                    if (mem_ready) begin
                        prox_estado_s = S_FETCH;
                    end else begin
                        prox_estado_s = S_MEMWR;
                    end
                end
                S_BRANCH: begin
                    ctrl_s.ula_src_a   = 1'b1;
                    ctrl_s.ula_src_b   = SRCB_REGB;
                    ctrl_s.ula_control = ULA_SUB;
                    ctrl_s.pc_src      = PCSRC_ULAOUT;
                    ctrl_s.branch      = 1'b1;
                    prox_estado_s      = S_FETCH;
                end
                S_ADDIEX: begin
                    ctrl_s.ula_src_a = 1'b1;
                    ctrl_s.ula_src_b = SRCB_IMM;
                    prox_estado_s    = S_ADDIWB;
                end
                S_ADDIWB: begin
                    ctrl_s.reg_write = 1'b1;
                    prox_estado_s    = S_FETCH;
                end
                S_JUMP: begin
                    ctrl_s.pc_src   = PCSRC_JUMP;
                    ctrl_s.pc_write = 1'b1;
                    prox_estado_s   = S_FETCH;
                end
                default: begin
                    prox_estado_s = S_FETCH;
                end
            endcase
        end
    end

    // bne takes the branch on a non-zero difference, beq on zero
    assign cond_branch_s = (opcode == OP_BNE) ? ~Zero : Zero;

    assign ULA_control = ctrl_s.ula_control;
    assign ULASrcA     = ctrl_s.ula_src_a;
    assign ULASrcB     = ctrl_s.ula_src_b;
    assign PCSrc       = ctrl_s.pc_src;
    assign PCEn        = ctrl_s.pc_write | (ctrl_s.branch & cond_branch_s);
    assign IorD        = ctrl_s.iord;
    assign IRWrite     = ctrl_s.ir_write;
    assign MemWrite    = ctrl_s.mem_write;
    assign RegWrite    = ctrl_s.reg_write;
    assign RegDst      = ctrl_s.reg_dst;
    assign MemtoReg    = ctrl_s.mem_to_reg;
    assign erro        = erro_r;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cnt_ciclos_r;
    logic [CNT_W-1:0] cnt_instr_r;
    logic             retira_s;

    // An instruction retires when a legal final state hands back to FETCH
    assign retira_s = !reset && (prox_estado_s == S_FETCH) &&
                      (estado_r inside {S_ALUWB, S_MEMWB, S_MEMWR, S_BRANCH, S_ADDIWB, S_JUMP});

    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ciclos_r <= {CNT_W{1'b0}};
            cnt_instr_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_ciclos_r <= cnt_ciclos_r + {{(CNT_W-1){1'b0}}, 1'b1};
            cnt_instr_r  <= cnt_instr_r + {{(CNT_W-1){1'b0}}, retira_s};
        end
    end

    assign cnt_ciclos = cnt_ciclos_r;
    assign cnt_instr  = cnt_instr_r;
`else
    assign cnt_ciclos = {CNT_W{1'b0}};
    assign cnt_instr  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for the multicycle MIPS control FSM. Per-cycle expected
// control vectors are queued as stimulus is driven and compared at the falling
// edge when the DUT presents them.
module tb_unidade_controle_multiciclo;

    typedef struct packed {
        logic [2:0] ula;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       iord;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       regdst;
        logic       m2r;
    } ctrl_t;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        Zero;
    logic        mem_ready;
    logic [2:0]  ULA_control;
    logic        ULASrcA;
    logic [1:0]  ULASrcB;
    logic [1:0]  PCSrc;
    logic        PCEn;
    logic        IorD;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        erro;
    logic [31:0] cnt_ciclos;
    logic [31:0] cnt_instr;

    int    checks = 0;
    int    errors = 0;
    int    exp_instr = 0;
    int    tb_cyc = 0;
    ctrl_t exp_q[$];

    unidade_controle_multiciclo #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .ULA_control(ULA_control), .ULASrcA(ULASrcA),
        .ULASrcB(ULASrcB), .PCSrc(PCSrc), .PCEn(PCEn), .IorD(IorD),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .erro(erro),
        .cnt_ciclos(cnt_ciclos), .cnt_instr(cnt_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side count of non-reset rising edges
    always @(posedge clk) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    function ctrl_t act();
        return {ULA_control, ULASrcA, ULASrcB, PCSrc, PCEn, IorD, IRWrite,
                MemWrite, RegWrite, RegDst, MemtoReg};
    endfunction

    function automatic ctrl_t mk(input logic [2:0] u, input logic a, input logic [1:0] b,
                                 input logic [1:0] p, input logic pe, input logic io,
                                 input logic ir, input logic mw, input logic rw,
                                 input logic rd, input logic mr);
        return {u, a, b, p, pe, io, ir, mw, rw, rd, mr};
    endfunction

    function automatic ctrl_t e_fetch(input logic m);  return mk(3'b010,1'b0,2'b01,2'b00,m,1'b0,m,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_decode();              return mk(3'b010,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_exec(input logic [2:0] u); return mk(u,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_aluwb();               return mk(3'b010,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0); endfunction
    function automatic ctrl_t e_memadr();              return mk(3'b010,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_memrd();               return mk(3'b010,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_memwb();               return mk(3'b010,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1); endfunction
    function automatic ctrl_t e_memwr();               return mk(3'b010,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_branch(input logic pe); return mk(3'b110,1'b1,2'b00,2'b01,pe,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_addiex();              return mk(3'b010,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction
    function automatic ctrl_t e_addiwb();              return mk(3'b010,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0); endfunction
    function automatic ctrl_t e_jump();                return mk(3'b010,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0); endfunction

    // Drive one cycle of inputs (called just after a rising edge) and queue
    // the control vector expected for it; returns at the falling edge.
    task automatic tick(input logic m, input logic z, input ctrl_t e);
        mem_ready = m;
        Zero      = z;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instr = 0;
    endtask

    task automatic test_reset();
        ctrl_t g;
        reset = 1'b1; opcode = 6'b000000; funct = 6'b100000; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        g = act();
        checks++;
        if ({g.pcen, g.irw, g.memw, g.regw} !== 4'b0000 || g.ula !== 3'b010) begin
            errors++;
            $display("FAIL reset_outputs: got enables=%b ula=%b expected enables=0000 ula=010",
                     {g.pcen, g.irw, g.memw, g.regw}, g.ula);
        end
        checks++;
        if (erro !== 1'b0 || cnt_ciclos !== 32'd0 || cnt_instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got erro=%b ciclos=%0d instr=%0d expected 0/0/0", erro, cnt_ciclos, cnt_instr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instr = 0;
    endtask

    task automatic test_add();
        ctrl_t e[4];
        ctrl_t g, w;
        opcode = 6'b000000; funct = 6'b100000;
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_exec(3'b010); e[3] = e_aluwb();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL add[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        exp_instr++;
        checks++;
        if (cnt_instr !== exp_cnt(exp_instr) || cnt_ciclos !== exp_cnt(tb_cyc)) begin
            errors++;
            $display("FAIL add_counters: got instr=%0d ciclos=%0d expected instr=%0d ciclos=%0d",
                     cnt_instr, cnt_ciclos, exp_cnt(exp_instr), exp_cnt(tb_cyc));
        end
    endtask

    task automatic test_lw();
        ctrl_t e[9];
        logic  m[9];
        ctrl_t g, w;
        int    n_iord = 0;
        int    n_wb = 0;
        opcode = 6'b100011;
        m = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        e[0] = e_fetch(1'b0); e[1] = e_fetch(1'b1); e[2] = e_decode(); e[3] = e_memadr();
        e[4] = e_memrd(); e[5] = e_memrd(); e[6] = e_memrd(); e[7] = e_memrd(); e[8] = e_memwb();
        for (int i = 0; i < 9; i++) begin
            tick(m[i], 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            if (g.iord) n_iord++;
            if (g.regw && g.m2r) n_wb++;
            checks++;
            if (g !== w) begin errors++; $display("FAIL lw[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        exp_instr++;
        checks++;
        if (n_iord !== 4 || n_wb !== 1) begin
            errors++;
            $display("FAIL lw_stall: got iord_cycles=%0d wb_cycles=%0d expected 4 and 1", n_iord, n_wb);
        end
    endtask

    task automatic test_sw();
        ctrl_t e[5];
        logic  m[5];
        ctrl_t g, w;
        opcode = 6'b101011;
        m = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_memadr(); e[3] = e_memwr(); e[4] = e_memwr();
        for (int i = 0; i < 5; i++) begin
            tick(m[i], 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL sw[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        exp_instr++;
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic want);
        ctrl_t e[3];
        ctrl_t g, w;
        opcode = op;
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_branch(want);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, z, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL branch op=%b z=%b [%0d]: got %b expected %b", op, z, i, g, w); end
            @(posedge clk); #1;
        end
        exp_instr++;
    endtask

    task automatic test_addi();
        ctrl_t e[4];
        ctrl_t g, w;
        opcode = 6'b001000;
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_addiex(); e[3] = e_addiwb();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL addi[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        exp_instr++;
    endtask

    task automatic test_jump();
        ctrl_t e[3];
        ctrl_t g, w;
        opcode = 6'b000010;
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_jump();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL jump[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        exp_instr++;
    endtask

    task automatic test_illegal_op();
        ctrl_t e[2];
        ctrl_t g, w;
        checks++;
        if (erro !== 1'b0) begin errors++; $display("FAIL illop_pre: got erro=%b expected 0", erro); end
        opcode = 6'b111111;
        e[0] = e_fetch(1'b1); e[1] = e_decode();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL illop[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        checks++;
        if (erro !== 1'b1) begin errors++; $display("FAIL illop_erro: got erro=%b expected 1", erro); end
        test_add();
        checks++;
        if (erro !== 1'b1) begin errors++; $display("FAIL illop_sticky: got erro=%b expected 1", erro); end
    endtask

    task automatic test_illegal_funct();
        ctrl_t e[3];
        ctrl_t g, w;
        opcode = 6'b000000; funct = 6'b000001;
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_exec(3'b010);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL illfn[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        checks++;
        if (erro !== 1'b1 || cnt_instr !== exp_cnt(exp_instr)) begin
            errors++;
            $display("FAIL illfn_erro: got erro=%b instr=%0d expected erro=1 instr=%0d", erro, cnt_instr, exp_cnt(exp_instr));
        end
        test_add();
    endtask

    task automatic test_reset_memwr();
        ctrl_t e[3];
        ctrl_t g, w;
        opcode = 6'b101011;
        e[0] = e_fetch(1'b1); e[1] = e_decode(); e[2] = e_memadr();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, e[i]);
            g = act(); w = exp_q.pop_front();
            checks++;
            if (g !== w) begin errors++; $display("FAIL rstwr[%0d]: got %b expected %b", i, g, w); end
            @(posedge clk); #1;
        end
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({MemWrite, RegWrite, IRWrite, PCEn} !== 4'b0000 || ULA_control !== 3'b010) begin
            errors++;
            $display("FAIL rstwr_abort: got mw/rw/ir/pcen=%b ula=%b expected 0000 010",
                     {MemWrite, RegWrite, IRWrite, PCEn}, ULA_control);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instr = 0;
        checks++;
        if (erro !== 1'b0 || cnt_ciclos !== 32'd0 || cnt_instr !== 32'd0) begin
            errors++;
            $display("FAIL rstwr_state: got erro=%b ciclos=%0d instr=%0d expected 0/0/0", erro, cnt_ciclos, cnt_instr);
        end
        test_add();
    endtask

    task automatic test_perf();
        do_reset();
        funct = 6'b100000;
        test_add();
        test_lw();
        test_sw();
        test_branch(6'b000100, 1'b1, 1'b1);
        test_jump();
        // add 4 + lw 9 + sw 5 + beq 3 + j 3 cycles
        checks++;
        if (cnt_instr !== exp_cnt(5) || cnt_ciclos !== exp_cnt(24)) begin
            errors++;
            $display("FAIL perf_counters: got instr=%0d ciclos=%0d expected instr=%0d ciclos=%0d",
                     cnt_instr, cnt_ciclos, exp_cnt(5), exp_cnt(24));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_branch(6'b000100, 1'b1, 1'b1);
        test_branch(6'b000100, 1'b0, 1'b0);
        test_branch(6'b000101, 1'b0, 1'b1);
        test_branch(6'b000101, 1'b1, 1'b0);
        test_addi();
        test_jump();
        test_illegal_op();
        test_reset_memwr();
        test_illegal_funct();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
